// File: rtl/simmem_pkg.sv
// Shared types and sizing for the simulated memory controller.
// Write responses carry the AXI ID plus an opaque content field (BRESP/BUSER).
package simmem_pkg;

  localparam int unsigned IdWidth                = 4;
  localparam int unsigned WriteRespContentWidth  = 8;
  localparam int unsigned WriteRespBankCapacity  = 16;
  localparam int unsigned WriteRespBankAddrWidth = $clog2(WriteRespBankCapacity);

  typedef struct packed {
    logic [IdWidth-1:0]               id;
    logic [WriteRespContentWidth-1:0] content;
  } wresp_t;

endpackage

// File: rtl/simmem_wresp_age_matrix.sv
// Relative-age tracker for the write response bank slots: set-youngest on allocation,
// pairwise older-than query, and oldest-of-mask one-hot selection for two masks.
module simmem_wresp_age_matrix #(
  parameter int unsigned Capacity = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               set_en_i,
  input  logic [Capacity-1:0]                set_onehot_i,
  input  logic [Capacity-1:0]                mask_a_i,
  output logic [Capacity-1:0]                oldest_a_o,
  input  logic [Capacity-1:0]                mask_b_i,
  output logic [Capacity-1:0]                oldest_b_o,
  output logic [Capacity-1:0][Capacity-1:0]  older_o
);

  // older_q[i][j] = 1 means slot i was allocated before slot j.
  logic [Capacity-1:0][Capacity-1:0] older_q, older_d;

  function automatic logic [Capacity-1:0] oldest_of(
    input logic [Capacity-1:0]               mask,
    input logic [Capacity-1:0][Capacity-1:0] older
  );
    logic [Capacity-1:0] res;
    for (int i = 0; i < Capacity; i++) begin
      res[i] = mask[i];
      for (int j = 0; j < Capacity; j++) begin
        if ((j != i) && mask[j] && older[j][i]) begin
          res[i] = 1'b0;
        end
      end
    end
    return res;
  endfunction

  // Newly allocated slot becomes younger than every other slot.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < Capacity; i++) begin
      for (int j = 0; j < Capacity; j++) begin
        if (set_en_i && set_onehot_i[i]) begin
          older_d[i][j] = 1'b0;
        end else if (set_en_i && set_onehot_i[j]) begin
          older_d[i][j] = 1'b1;
        end else begin
          older_d[i][j] = older_q[i][j];
        end
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

  assign oldest_a_o = oldest_of(mask_a_i, older_q);
  assign oldest_b_o = oldest_of(mask_b_i, older_q);
  assign older_o    = older_q;

endmodule

// File: rtl/simmem_wresp_bank.sv
// Write response bank: reserves slots per write address, stores responses, releases them in
// AXI per-ID order once enabled. Optional SIMMEM_WRESP_BANK_STATS_EN adds occupancy statistics.
module simmem_wresp_bank
  import simmem_pkg::*;
#(
  parameter  int unsigned Capacity  = simmem_pkg::WriteRespBankCapacity,
  parameter  int unsigned IdWidth   = simmem_pkg::IdWidth,
  localparam int unsigned AddrWidth = $clog2(Capacity)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [IdWidth-1:0]   waddr_id_i,
  input  logic                 waddr_valid_i,
  output logic                 waddr_ready_o,
  output logic [AddrWidth-1:0] waddr_iid_o,
  input  wresp_t               wresp_in_i,
  input  logic                 wresp_in_valid_i,
  output logic                 wresp_in_ready_o,
  input  logic [Capacity-1:0]  release_en_onehot_i,
  output logic [Capacity-1:0]  released_addr_onehot_o,
  output wresp_t               wresp_out_o,
  output logic                 wresp_out_valid_o,
  input  logic                 wresp_out_ready_i
`ifdef SIMMEM_WRESP_BANK_STATS_EN
  ,
  output logic [AddrWidth:0]   occupancy_o,
  output logic [AddrWidth:0]   max_occupancy_o
`endif
);

  typedef enum logic [1:0] {
    SlotFree     = 2'd0,
    SlotReserved = 2'd1,
    SlotLoaded   = 2'd2
  } slot_state_e;

  slot_state_e                                   state_q [Capacity];
  slot_state_e                                   state_d [Capacity];
  logic [Capacity-1:0][IdWidth-1:0]               id_q, id_d;
  logic [Capacity-1:0][WriteRespContentWidth-1:0] content_q, content_d;
  logic [Capacity-1:0]                           rel_en_q, rel_en_d;
  logic                                          lock_q, lock_d;
  logic [Capacity-1:0]                           lock_oh_q, lock_oh_d;

  logic [Capacity-1:0]                           free_s, reserved_s, loaded_s, nonfree_s;
  logic [Capacity-1:0]                           match_s, blocked_s, eligible_s;
  logic [Capacity-1:0]                           alloc_oh_s, load_oh_s, oldest_elig_s, sel_oh_s;
  logic [Capacity-1:0][Capacity-1:0]             older_s;
  logic [AddrWidth-1:0]                          sel_idx_s;
  logic                                          waddr_hs_s, load_hs_s, out_hs_s;

  function automatic logic [AddrWidth-1:0] lowest_index(input logic [Capacity-1:0] vec);
    logic [AddrWidth-1:0] idx;
    idx = '0;
    for (int i = int'(Capacity) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = AddrWidth'(i);
      end
    end
    return idx;
  endfunction

  // Slot classification and per-ID ordering, all from registered state.
  always_comb begin
    free_s     = '0;
    reserved_s = '0;
    loaded_s   = '0;
    match_s    = '0;
    blocked_s  = '0;
    for (int i = 0; i < Capacity; i++) begin
      free_s[i]     = (state_q[i] == SlotFree);
      reserved_s[i] = (state_q[i] == SlotReserved);
      loaded_s[i]   = (state_q[i] == SlotLoaded);
      match_s[i]    = reserved_s[i] && (id_q[i] == wresp_in_i.id);
    end
    nonfree_s = ~free_s;
    for (int i = 0; i < Capacity; i++) begin
      for (int j = 0; j < Capacity; j++) begin
        if ((j != i) && nonfree_s[j] && (id_q[j] == id_q[i]) && older_s[j][i]) begin
          blocked_s[i] = 1'b1;
        end
      end
    end
    eligible_s = loaded_s & rel_en_q & ~blocked_s;
  end

  assign alloc_oh_s       = free_s & (~free_s + Capacity'(1));
  assign waddr_ready_o    = |free_s;
  assign waddr_iid_o      = lowest_index(free_s);
  assign waddr_hs_s       = waddr_valid_i && waddr_ready_o;

  assign wresp_in_ready_o = |match_s;
  assign load_hs_s        = wresp_in_valid_i && wresp_in_ready_o;

  simmem_wresp_age_matrix #(
    .Capacity (Capacity)
  ) u_age_matrix (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .set_en_i     (waddr_hs_s),
    .set_onehot_i (alloc_oh_s),
    .mask_a_i     (match_s),
    .oldest_a_o   (load_oh_s),
    .mask_b_i     (eligible_s),
    .oldest_b_o   (oldest_elig_s),
    .older_o      (older_s)
  );

  // A presented-but-stalled response keeps its slot until the requester takes it.
  assign sel_oh_s               = lock_q ? lock_oh_q : oldest_elig_s;
  assign sel_idx_s              = lowest_index(sel_oh_s);
  assign wresp_out_valid_o      = lock_q || (|eligible_s);
  assign wresp_out_o.id         = id_q[sel_idx_s];
  assign wresp_out_o.content    = content_q[sel_idx_s];
  assign out_hs_s               = wresp_out_valid_o && wresp_out_ready_i;
  assign released_addr_onehot_o = out_hs_s ? sel_oh_s : '0;

  // Slot next-state: release, load and reserve touch disjoint slots by construction.
  always_comb begin
    id_d      = id_q;
    content_d = content_q;
    rel_en_d  = rel_en_q;
    for (int i = 0; i < Capacity; i++) begin
      state_d[i]  = state_q[i];
      rel_en_d[i] = rel_en_q[i] | (release_en_onehot_i[i] & nonfree_s[i]);
      if (released_addr_onehot_o[i]) begin
        state_d[i]  = SlotFree;
        rel_en_d[i] = 1'b0;
      end else if (load_hs_s && load_oh_s[i]) begin
        state_d[i]   = SlotLoaded;
        content_d[i] = wresp_in_i.content;
      end else if (waddr_hs_s && alloc_oh_s[i]) begin
        state_d[i] = SlotReserved;
        id_d[i]    = waddr_id_i;
      end else begin
        state_d[i] = state_q[i];
      end
    end
  end

  // Output lock next-state.
  always_comb begin
    if (wresp_out_valid_o && !wresp_out_ready_i) begin
      lock_d    = 1'b1;
      lock_oh_d = sel_oh_s;
    end else begin
      lock_d    = 1'b0;
      lock_oh_d = '0;
    end
  end

  // Slot and lock registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Capacity; i++) begin
        state_q[i] <= SlotFree;
      end
      id_q      <= '0;
      content_q <= '0;
      rel_en_q  <= '0;
      lock_q    <= 1'b0;
      lock_oh_q <= '0;
    end else begin
      for (int i = 0; i < Capacity; i++) begin
        state_q[i] <= state_d[i];
      end
      id_q      <= id_d;
      content_q <= content_d;
      rel_en_q  <= rel_en_d;
      lock_q    <= lock_d;
      lock_oh_q <= lock_oh_d;
    end
  end

`ifdef SIMMEM_WRESP_BANK_STATS_EN
  logic [AddrWidth:0] occupancy_q, occupancy_d;
  logic [AddrWidth:0] max_occupancy_q, max_occupancy_d;

  function automatic logic [AddrWidth:0] popcount(input logic [Capacity-1:0] vec);
    logic [AddrWidth:0] cnt;
    cnt = '0;
    for (int i = 0; i < Capacity; i++) begin
      cnt = cnt + (AddrWidth + 1)'(vec[i]);
    end
    return cnt;
  endfunction

  // Occupancy tracks the slot state being committed this cycle.
  always_comb begin
    logic [Capacity-1:0] nonfree_next;
    nonfree_next = '0;
    for (int i = 0; i < Capacity; i++) begin
      nonfree_next[i] = (state_d[i] != SlotFree);
    end
    occupancy_d = popcount(nonfree_next);
    if (occupancy_d > max_occupancy_q) begin
      max_occupancy_d = occupancy_d;
    end else begin
      max_occupancy_d = max_occupancy_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupancy_q     <= '0;
      max_occupancy_q <= '0;
    end else begin
      occupancy_q     <= occupancy_d;
      max_occupancy_q <= max_occupancy_d;
    end
  end

  assign occupancy_o     = occupancy_q;
  assign max_occupancy_o = max_occupancy_q;
`endif

endmodule

// File: tb/tb_simmem_wresp_bank.sv
// Directed self-checking bench for simmem_wresp_bank; expected values are hand-computed.
module tb_simmem_wresp_bank;
  import simmem_pkg::*;

  localparam int unsigned Cap = WriteRespBankCapacity;
  localparam int unsigned AW  = WriteRespBankAddrWidth;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [IdWidth-1:0] waddr_id_i;
  logic               waddr_valid_i;
  logic               waddr_ready_o;
  logic [AW-1:0]      waddr_iid_o;
  wresp_t             wresp_in_i;
  logic               wresp_in_valid_i;
  logic               wresp_in_ready_o;
  logic [Cap-1:0]     release_en_onehot_i;
  logic [Cap-1:0]     released_addr_onehot_o;
  wresp_t             wresp_out_o;
  logic               wresp_out_valid_o;
  logic               wresp_out_ready_i;
`ifdef SIMMEM_WRESP_BANK_STATS_EN
  logic [AW:0]        occupancy_o;
  logic [AW:0]        max_occupancy_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  simmem_wresp_bank dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .waddr_id_i             (waddr_id_i),
    .waddr_valid_i          (waddr_valid_i),
    .waddr_ready_o          (waddr_ready_o),
    .waddr_iid_o            (waddr_iid_o),
    .wresp_in_i             (wresp_in_i),
    .wresp_in_valid_i       (wresp_in_valid_i),
    .wresp_in_ready_o       (wresp_in_ready_o),
    .release_en_onehot_i    (release_en_onehot_i),
    .released_addr_onehot_o (released_addr_onehot_o),
    .wresp_out_o            (wresp_out_o),
    .wresp_out_valid_o      (wresp_out_valid_o),
    .wresp_out_ready_i      (wresp_out_ready_i)
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    ,
    .occupancy_o            (occupancy_o),
    .max_occupancy_o        (max_occupancy_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni              = 1'b0;
    waddr_id_i          = '0;
    waddr_valid_i       = 1'b0;
    wresp_in_i          = '0;
    wresp_in_valid_i    = 1'b0;
    release_en_onehot_i = '0;
    wresp_out_ready_i   = 1'b0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic reserve(input logic [IdWidth-1:0] id);
    waddr_valid_i = 1'b1;
    waddr_id_i    = id;
    cyc();
    waddr_valid_i = 1'b0;
  endtask

  task automatic load(input logic [IdWidth-1:0] id, input logic [WriteRespContentWidth-1:0] c);
    wresp_in_valid_i   = 1'b1;
    wresp_in_i.id      = id;
    wresp_in_i.content = c;
    cyc();
    wresp_in_valid_i = 1'b0;
  endtask

  task automatic enable(input logic [Cap-1:0] m);
    release_en_onehot_i = m;
    cyc();
    release_en_onehot_i = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (waddr_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_waddr_ready: got %b want 1", waddr_ready_o); end
    n_checks++; if (waddr_iid_o !== 4'd0) begin n_fail++; $display("FAIL reset_iid: got %0d want 0", waddr_iid_o); end
    n_checks++; if (wresp_in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", wresp_in_ready_o); end
    n_checks++; if (wresp_out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", wresp_out_valid_o); end
    n_checks++; if (released_addr_onehot_o !== 16'h0000) begin n_fail++; $display("FAIL reset_released: got %h want 0000", released_addr_onehot_o); end
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    n_checks++; if (occupancy_o !== 5'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy_o); end
    n_checks++; if (max_occupancy_o !== 5'd0) begin n_fail++; $display("FAIL reset_max_occ: got %0d want 0", max_occupancy_o); end
`endif
  endtask

  task automatic test_per_id_order();
    do_reset();
    waddr_valid_i = 1'b1;
    waddr_id_i    = 4'd3;
    #1;
    n_checks++; if (waddr_iid_o !== 4'd0) begin n_fail++; $display("FAIL order_iid0: got %0d want 0", waddr_iid_o); end
    cyc();
    n_checks++; if (waddr_iid_o !== 4'd1) begin n_fail++; $display("FAIL order_iid1: got %0d want 1", waddr_iid_o); end
    cyc();
    waddr_valid_i = 1'b0;
    load(4'd3, 8'hA1);
    load(4'd3, 8'hB2);
    enable(16'h0002);
    n_checks++; if (wresp_out_valid_o !== 1'b0) begin n_fail++; $display("FAIL order_blocked: got %b want 0", wresp_out_valid_o); end
    enable(16'h0001);
    n_checks++; if (wresp_out_valid_o !== 1'b1 || wresp_out_o.content !== 8'hA1) begin n_fail++; $display("FAIL order_first: valid %b content %h want 1 a1", wresp_out_valid_o, wresp_out_o.content); end
    wresp_out_ready_i = 1'b1;
    #1;
    n_checks++; if (released_addr_onehot_o !== 16'h0001) begin n_fail++; $display("FAIL order_rel0: got %h want 0001", released_addr_onehot_o); end
    cyc();
    n_checks++; if (wresp_out_valid_o !== 1'b1 || wresp_out_o.content !== 8'hB2) begin n_fail++; $display("FAIL order_second: valid %b content %h want 1 b2", wresp_out_valid_o, wresp_out_o.content); end
    n_checks++; if (released_addr_onehot_o !== 16'h0002) begin n_fail++; $display("FAIL order_rel1: got %h want 0002", released_addr_onehot_o); end
    cyc();
    wresp_out_ready_i = 1'b0;
    #1;
    n_checks++; if (wresp_out_valid_o !== 1'b0) begin n_fail++; $display("FAIL order_drained: got %b want 0", wresp_out_valid_o); end
  endtask

  task automatic test_min_latency();
    do_reset();
    reserve(4'd1);
    reserve(4'd2);
    load(4'd1, 8'h11);
    load(4'd2, 8'h22);
    release_en_onehot_i = 16'h0002;
    #1;
    n_checks++; if (wresp_out_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b want 0", wresp_out_valid_o); end
    cyc();
    release_en_onehot_i = '0;
    n_checks++; if (wresp_out_valid_o !== 1'b1 || wresp_out_o.id !== 4'd2 || wresp_out_o.content !== 8'h22) begin n_fail++; $display("FAIL lat_out: valid %b id %0d content %h want 1 2 22", wresp_out_valid_o, wresp_out_o.id, wresp_out_o.content); end
    wresp_out_ready_i = 1'b1;
    #1;
    n_checks++; if (released_addr_onehot_o !== 16'h0002) begin n_fail++; $display("FAIL lat_rel: got %h want 0002", released_addr_onehot_o); end
    cyc();
    wresp_out_ready_i = 1'b0;
    #1;
    n_checks++; if (wresp_out_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_slot0_held: got %b want 0", wresp_out_valid_o); end
    n_checks++; if (waddr_iid_o !== 4'd1) begin n_fail++; $display("FAIL lat_iid: got %0d want 1", waddr_iid_o); end
  endtask

  task automatic test_full();
    do_reset();
    waddr_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      waddr_id_i = IdWidth'(i);
      #1;
      n_checks++; if (waddr_iid_o !== AW'(i)) begin n_fail++; $display("FAIL full_iid%0d: got %0d want %0d", i, waddr_iid_o, i); end
      cyc();
    end
    waddr_valid_i = 1'b0;
    #1;
    n_checks++; if (waddr_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", waddr_ready_o); end
    load(4'd5, 8'h55);
    enable(16'h0020);
    n_checks++; if (wresp_out_valid_o !== 1'b1 || wresp_out_o.id !== 4'd5) begin n_fail++; $display("FAIL full_out: valid %b id %0d want 1 5", wresp_out_valid_o, wresp_out_o.id); end
    wresp_out_ready_i = 1'b1;
    #1;
    n_checks++; if (released_addr_onehot_o !== 16'h0020) begin n_fail++; $display("FAIL full_rel: got %h want 0020", released_addr_onehot_o); end
    n_checks++; if (waddr_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_no_reuse: got %b want 0", waddr_ready_o); end
    cyc();
    wresp_out_ready_i = 1'b0;
    #1;
    n_checks++; if (waddr_ready_o !== 1'b1 || waddr_iid_o !== 4'd5) begin n_fail++; $display("FAIL full_regrant: ready %b iid %0d want 1 5", waddr_ready_o, waddr_iid_o); end
  endtask

  task automatic test_lock();
    do_reset();
    reserve(4'd0);
    reserve(4'd1);
    reserve(4'd2);
    load(4'd2, 8'hC2);
    load(4'd0, 8'hC0);
    enable(16'h0004);
    n_checks++; if (wresp_out_valid_o !== 1'b1 || wresp_out_o.content !== 8'hC2) begin n_fail++; $display("FAIL lock_first: valid %b content %h want 1 c2", wresp_out_valid_o, wresp_out_o.content); end
    enable(16'h0001);
    n_checks++; if (wresp_out_o.id !== 4'd2 || wresp_out_o.content !== 8'hC2) begin n_fail++; $display("FAIL lock_hold: id %0d content %h want 2 c2", wresp_out_o.id, wresp_out_o.content); end
    cyc();
    n_checks++; if (wresp_out_valid_o !== 1'b1 || wresp_out_o.content !== 8'hC2) begin n_fail++; $display("FAIL lock_hold2: valid %b content %h want 1 c2", wresp_out_valid_o, wresp_out_o.content); end
    wresp_out_ready_i = 1'b1;
    #1;
    n_checks++; if (released_addr_onehot_o !== 16'h0004) begin n_fail++; $display("FAIL lock_rel2: got %h want 0004", released_addr_onehot_o); end
    cyc();
    n_checks++; if (wresp_out_valid_o !== 1'b1 || wresp_out_o.content !== 8'hC0) begin n_fail++; $display("FAIL lock_next: valid %b content %h want 1 c0", wresp_out_valid_o, wresp_out_o.content); end
    n_checks++; if (released_addr_onehot_o !== 16'h0001) begin n_fail++; $display("FAIL lock_rel0: got %h want 0001", released_addr_onehot_o); end
    cyc();
    wresp_out_ready_i = 1'b0;
    #1;
    n_checks++; if (wresp_out_valid_o !== 1'b0) begin n_fail++; $display("FAIL lock_drained: got %b want 0", wresp_out_valid_o); end
  endtask

  task automatic test_no_match();
    do_reset();
    reserve(4'd3);
    wresp_in_valid_i   = 1'b1;
    wresp_in_i.id      = 4'd7;
    wresp_in_i.content = 8'h77;
    #1;
    n_checks++; if (wresp_in_ready_o !== 1'b0) begin n_fail++; $display("FAIL nomatch_ready: got %b want 0", wresp_in_ready_o); end
    cyc();
    cyc();
    wresp_in_valid_i = 1'b0;
    #1;
    n_checks++; if (waddr_iid_o !== 4'd1 || wresp_out_valid_o !== 1'b0) begin n_fail++; $display("FAIL nomatch_state: iid %0d valid %b want 1 0", waddr_iid_o, wresp_out_valid_o); end
    wresp_in_i.id = 4'd3;
    #1;
    n_checks++; if (wresp_in_ready_o !== 1'b1) begin n_fail++; $display("FAIL nomatch_still_reserved: got %b want 1", wresp_in_ready_o); end
    reserve(4'd4);
    reserve(4'd5);
`ifdef SIMMEM_WRESP_BANK_STATS_EN
    n_checks++; if (occupancy_o !== 5'd3) begin n_fail++; $display("FAIL stats_occ: got %0d want 3", occupancy_o); end
    n_checks++; if (max_occupancy_o !== 5'd3) begin n_fail++; $display("FAIL stats_max: got %0d want 3", max_occupancy_o); end
`endif
    n_checks++; if (waddr_iid_o !== 4'd3) begin n_fail++; $display("FAIL nomatch_iid3: got %0d want 3", waddr_iid_o); end
  endtask

  initial begin
    rst_ni              = 1'b0;
    waddr_id_i          = '0;
    waddr_valid_i       = 1'b0;
    wresp_in_i          = '0;
    wresp_in_valid_i    = 1'b0;
    release_en_onehot_i = '0;
    wresp_out_ready_i   = 1'b0;
    test_reset();
    test_per_id_order();
    test_min_latency();
    test_full();
    test_lock();
    test_no_match();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
